// File: rtl/wb_stage_multi_pkg.sv
// Shared definitions for the multi-lane writeback stage: exception bit
// layout, LoongArch-style ecode/esubcode values and the flush FSM encoding.
package wb_stage_multi_pkg;

    // bit positions inside a lane's 6-bit exc_type vector
    localparam int EXC_W    = 6;
    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_INE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_ALE  = 5;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_e;

    // Priority INT > ADEF > INE > SYS > BRK > ALE
    function automatic logic [5:0] exc_ecode(input logic [EXC_W-1:0] t);
        if (t[EXC_INT])       return ECODE_INT;
        else if (t[EXC_ADEF]) return ECODE_ADE;
        else if (t[EXC_INE])  return ECODE_INE;
        else if (t[EXC_SYS])  return ECODE_SYS;
        else if (t[EXC_BRK])  return ECODE_BRK;
        else if (t[EXC_ALE])  return ECODE_ALE;
        else                  return 6'h00;
    endfunction

    // Only ADEF carries a subcode, and only when nothing outranks it
    function automatic logic [8:0] exc_esubcode(input logic [EXC_W-1:0] t);
        if (!t[EXC_INT] && t[EXC_ADEF]) return ESUBCODE_ADEF;
        else                            return 9'h000;
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Debug trace FIFO: accepts up to LANES entries per cycle (compacted in lane
// order), drains one entry per cycle. DEPTH must be a power of two >= 2.
module wb_trace_fifo
    import wb_stage_multi_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [LANES-1:0]            push,
    input  logic [LANES-1:0][XLEN-1:0]  push_pc,
    input  logic [LANES-1:0][4:0]       push_wnum,
    input  logic [LANES-1:0][XLEN-1:0]  push_wdata,
    output logic                        room,
    output logic                        head_valid,
    output logic [XLEN-1:0]             head_pc,
    output logic [4:0]                  head_wnum,
    output logic [XLEN-1:0]             head_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    logic [DEPTH-1:0][XLEN-1:0] mem_pc;
    logic [DEPTH-1:0][XLEN-1:0] mem_wdata;
    logic [DEPTH-1:0][4:0]      mem_wnum;
    logic [PW-1:0]              wptr, rptr;
    logic [CW-1:0]              count, npush, acc;
    logic [LANES-1:0][PW-1:0]   off;
    logic                       pop;

    assign pop        = (count != '0);
    assign head_valid = pop;
    assign room       = (DEPTH_C - count) >= LANES_C;
    assign head_pc    = pop ? mem_pc[rptr]    : '0;
    assign head_wnum  = pop ? mem_wnum[rptr]  : '0;
    assign head_wdata = pop ? mem_wdata[rptr] : '0;

    // slot offset of each pushing lane = number of pushing lanes below it
    always_comb begin
        acc = '0;
        off = '0;
        for (int i = 0; i < LANES; i++) begin
            off[i] = acc[PW-1:0];
            acc    = acc + {{(CW-1){1'b0}}, push[i]};
        end
        npush = acc;
    end

    // pointers and occupancy; reset discards any pending entries
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + npush[PW-1:0];
            rptr  <= rptr + {{(PW-1){1'b0}}, pop};
            count <= count + npush - {{(CW-1){1'b0}}, pop};
        end
    end

    // storage writes; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem_pc[wptr + off[i]]    <= push_pc[i];
                mem_wnum[wptr + off[i]]  <= push_wnum[i];
                mem_wdata[wptr + off[i]] <= push_wdata[i];
            end
        end
    end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: commits GPR/CSR writes, raises the oldest
// exception or ERTN, kills stale bundles after a flush via an epoch tag and
// serializes committed GPR writes into a debug trace.
module wb_stage_multi
    import wb_stage_multi_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int XLEN        = 32,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [LANES-1:0]        mem_wb_valid,
    input  logic [LANES-1:0]        mem_wb_gr_we,
    input  logic [LANES-1:0]        mem_wb_ertn,
    input  logic [5*LANES-1:0]      mem_wb_dest,
    input  logic [XLEN*LANES-1:0]   mem_wb_result,
    input  logic [XLEN*LANES-1:0]   mem_wb_pc,
    input  logic [6*LANES-1:0]      mem_wb_exc_type,
    input  logic                    mem_wb_epoch,
    input  logic                    mem_wb_csr_we,
    input  logic [13:0]             mem_wb_csr_waddr,
    input  logic [XLEN-1:0]         mem_wb_csr_wmask,
    input  logic [XLEN-1:0]         mem_wb_csr_wdata,
    output logic                    wb_allowin,
    output logic [LANES-1:0]        rf_we,
    output logic [5*LANES-1:0]      rf_waddr,
    output logic [XLEN*LANES-1:0]   rf_wdata,
    output logic                    csr_we,
    output logic [13:0]             csr_waddr,
    output logic [XLEN-1:0]         csr_wmask,
    output logic [XLEN-1:0]         csr_wdata,
    output logic                    wb_exc,
    output logic [5:0]              wb_ecode,
    output logic [8:0]              wb_esubcode,
    output logic [XLEN-1:0]         wb_pc,
    output logic [XLEN-1:0]         wb_badvaddr,
    output logic                    ertn_flush,
    output logic [15:0]             wb_csr_blk_bus,
    output logic [XLEN-1:0]         debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [4:0]              debug_wb_rf_wnum,
    output logic [XLEN-1:0]         debug_wb_rf_wdata
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]               wb_valid, gr_we_r, ertn_r;
    logic [LANES-1:0][4:0]          dest_r;
    logic [LANES-1:0][XLEN-1:0]     result_r, pc_r;
    logic [LANES-1:0][EXC_W-1:0]    exc_r;
    logic                           bundle_epoch_r, csr_we_r;
    logic [13:0]                    csr_waddr_r;
    logic [XLEN-1:0]                csr_wmask_r, csr_wdata_r;

    wb_state_e                      state, state_nxt;
    logic                           epoch_r, flushing, killed;
    logic                           ready_go, load, has_e, exc_go, ertn_go, csr_go;
    logic [LW-1:0]                  e_idx;
    logic [LANES-1:0]               lane_ok, rf_we_int;
    logic                           head_valid;

    assign load       = (|mem_wb_valid) & wb_allowin;
    assign wb_allowin = ~(|wb_valid) | ready_go;
    assign killed     = flushing & (bundle_epoch_r != epoch_r);

    // lane valids follow the input whenever the stage can accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         wb_valid <= '0;
        else if (wb_allowin) wb_valid <= mem_wb_valid;
    end

    // bundle payload, captured only on an accepted bundle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gr_we_r        <= '0;
            ertn_r         <= '0;
            dest_r         <= '0;
            result_r       <= '0;
            pc_r           <= '0;
            exc_r          <= '0;
            bundle_epoch_r <= 1'b0;
            csr_we_r       <= 1'b0;
            csr_waddr_r    <= '0;
            csr_wmask_r    <= '0;
            csr_wdata_r    <= '0;
        end else if (load) begin
            gr_we_r        <= mem_wb_gr_we;
            ertn_r         <= mem_wb_ertn;
            dest_r         <= mem_wb_dest;
            result_r       <= mem_wb_result;
            pc_r           <= mem_wb_pc;
            exc_r          <= mem_wb_exc_type;
            bundle_epoch_r <= mem_wb_epoch;
            csr_we_r       <= mem_wb_csr_we;
            csr_waddr_r    <= mem_wb_csr_waddr;
            csr_wmask_r    <= mem_wb_csr_wmask;
            csr_wdata_r    <= mem_wb_csr_wdata;
        end
    end

    // flush FSM state and epoch; every redirect flips the epoch
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_RUN;
            epoch_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (exc_go | ertn_go) epoch_r <= ~epoch_r;
        end
    end

    // leave FLUSH once a bundle tagged with the current epoch arrives
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (exc_go | ertn_go) state_nxt = ST_FLUSH;
            ST_FLUSH: begin
                if (exc_go | ertn_go)                      state_nxt = ST_FLUSH;
                else if (load && mem_wb_epoch == epoch_r)  state_nxt = ST_RUN;
            end
            default:  state_nxt = ST_RUN;
        endcase
    end

    // FSM output decode
    always_comb begin
        flushing = (state == ST_FLUSH);
    end

    // oldest live lane with any exception bit set
    always_comb begin
        has_e   = 1'b0;
        e_idx   = '0;
        lane_ok = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ok[i] = wb_valid[i] & ~killed;
            if (!has_e && lane_ok[i] && (|exc_r[i])) begin
                has_e = 1'b1;
                e_idx = LW'(i);
            end
        end
    end

    // commit decisions; the excepting lane and everything younger is dropped
    always_comb begin
        exc_go    = has_e & ready_go;
        ertn_go   = lane_ok[0] & ertn_r[0] & ~has_e & ready_go;
        csr_go    = lane_ok[0] & csr_we_r & ~(|exc_r[0]);
        rf_we_int = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we_int[i] = lane_ok[i] & gr_we_r[i] & ready_go
                         & ~(has_e && (LW'(i) >= e_idx))
                         & ~(ertn_go && (i != 0));
        end
    end

    assign rf_we          = rf_we_int;
    assign rf_waddr       = dest_r;
    assign rf_wdata       = result_r;

    assign csr_we         = csr_go & ready_go;
    assign csr_waddr      = csr_waddr_r;
    assign csr_wmask      = csr_wmask_r;
    assign csr_wdata      = csr_wdata_r;

    assign wb_exc         = exc_go;
    assign wb_ecode       = exc_go ? exc_ecode(exc_r[e_idx])    : 6'h00;
    assign wb_esubcode    = exc_go ? exc_esubcode(exc_r[e_idx]) : 9'h000;
    assign wb_pc          = exc_go ? pc_r[e_idx]                : '0;
    assign wb_badvaddr    = exc_go ? result_r[e_idx]            : '0;
    assign ertn_flush     = ertn_go;
    assign wb_csr_blk_bus = {csr_go, ertn_go, csr_waddr_r};

    assign debug_wb_rf_we = {4{head_valid}};

    wb_trace_fifo #(
        .LANES (LANES),
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .resetn     (resetn),
        .push       (rf_we_int),
        .push_pc    (pc_r),
        .push_wnum  (dest_r),
        .push_wdata (result_r),
        .room       (ready_go),
        .head_valid (head_valid),
        .head_pc    (debug_wb_pc),
        .head_wnum  (debug_wb_rf_wnum),
        .head_wdata (debug_wb_rf_wdata)
    );

endmodule

// File: tb/tb_wb_stage_multi.sv
// Bench for wb_stage_multi (LANES=2, XLEN=32, TRACE_DEPTH=4). Committed GPR
// writes are queued as expected trace entries and checked as they drain.
module tb_wb_stage_multi;
    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [LANES-1:0]       mem_wb_valid, mem_wb_gr_we, mem_wb_ertn;
    logic [5*LANES-1:0]     mem_wb_dest;
    logic [XLEN*LANES-1:0]  mem_wb_result, mem_wb_pc;
    logic [6*LANES-1:0]     mem_wb_exc_type;
    logic                   mem_wb_epoch, mem_wb_csr_we;
    logic [13:0]            mem_wb_csr_waddr;
    logic [XLEN-1:0]        mem_wb_csr_wmask, mem_wb_csr_wdata;
    logic                   wb_allowin;
    logic [LANES-1:0]       rf_we;
    logic [5*LANES-1:0]     rf_waddr;
    logic [XLEN*LANES-1:0]  rf_wdata;
    logic                   csr_we;
    logic [13:0]            csr_waddr;
    logic [XLEN-1:0]        csr_wmask, csr_wdata;
    logic                   wb_exc, ertn_flush;
    logic [5:0]             wb_ecode;
    logic [8:0]             wb_esubcode;
    logic [XLEN-1:0]        wb_pc, wb_badvaddr;
    logic [15:0]            wb_csr_blk_bus;
    logic [XLEN-1:0]        debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]             debug_wb_rf_we;
    logic [4:0]             debug_wb_rf_wnum;

    wb_stage_multi #(.LANES(LANES), .XLEN(XLEN), .TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .mem_wb_valid(mem_wb_valid), .mem_wb_gr_we(mem_wb_gr_we), .mem_wb_ertn(mem_wb_ertn),
        .mem_wb_dest(mem_wb_dest), .mem_wb_result(mem_wb_result), .mem_wb_pc(mem_wb_pc),
        .mem_wb_exc_type(mem_wb_exc_type), .mem_wb_epoch(mem_wb_epoch),
        .mem_wb_csr_we(mem_wb_csr_we), .mem_wb_csr_waddr(mem_wb_csr_waddr),
        .mem_wb_csr_wmask(mem_wb_csr_wmask), .mem_wb_csr_wdata(mem_wb_csr_wdata),
        .wb_allowin(wb_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .wb_exc(wb_exc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .wb_badvaddr(wb_badvaddr), .ertn_flush(ertn_flush), .wb_csr_blk_bus(wb_csr_blk_bus),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } tr_t;

    typedef struct {
        logic        v, we, ertn;
        logic [4:0]  d;
        logic [31:0] res, pc;
        logic [5:0]  exc;
    } lane_t;

    tr_t   exp_q[$];
    tr_t   mon_e;
    int    checks = 0;
    int    fails  = 0;
    int    stalls = 0;
    logic  cur_ep = 1'b0;
    lane_t nil;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic lane_t mk(input logic v, input logic we, input logic ertn,
                                 input logic [4:0] d, input logic [31:0] res,
                                 input logic [31:0] pc, input logic [5:0] exc);
        lane_t l;
        l.v = v; l.we = we; l.ertn = ertn; l.d = d; l.res = res; l.pc = pc; l.exc = exc;
        return l;
    endfunction

    task automatic exp_tr(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] wdata);
        tr_t t;
        t.pc = pc; t.wnum = wnum; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // drive a bundle (caller sits just after a rising edge) and wait for acceptance
    task automatic send(input lane_t a, input lane_t b, input logic ep);
        bit ok = 1'b0;
        mem_wb_valid    = {b.v, a.v};
        mem_wb_gr_we    = {b.we, a.we};
        mem_wb_ertn     = {b.ertn, a.ertn};
        mem_wb_dest     = {b.d, a.d};
        mem_wb_result   = {b.res, a.res};
        mem_wb_pc       = {b.pc, a.pc};
        mem_wb_exc_type = {b.exc, a.exc};
        mem_wb_epoch    = ep;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (wb_allowin) ok = 1'b1;
            else            stalls++;
            step();
        end
        chk("accept", 64'(ok), 64'd1);
        mem_wb_valid = '0;
    endtask

    // wait until every expected trace entry has drained, then realign
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || debug_wb_rf_we != 4'h0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("dbg_idle_pc", 64'(debug_wb_pc), 64'd0);
        step();
    endtask

    // trace monitor: every emitted entry must match the queue head
    always @(negedge clk) begin
        if (resetn && debug_wb_rf_we != 4'h0) begin
            if (exp_q.size() == 0) begin
                chk("trace_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("trace_we",    64'(debug_wb_rf_we),    64'hf);
                chk("trace_pc",    64'(debug_wb_pc),       64'(mon_e.pc));
                chk("trace_wnum",  64'(debug_wb_rf_wnum),  64'(mon_e.wnum));
                chk("trace_wdata", 64'(debug_wb_rf_wdata), 64'(mon_e.wdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nil = mk(0, 0, 0, 5'd0, 32'h0, 32'h0, 6'h0);
        resetn = 1'b0;
        mem_wb_valid = '0; mem_wb_gr_we = '0; mem_wb_ertn = '0; mem_wb_dest = '0;
        mem_wb_result = '0; mem_wb_pc = '0; mem_wb_exc_type = '0; mem_wb_epoch = 1'b0;
        mem_wb_csr_we = 1'b0; mem_wb_csr_waddr = '0; mem_wb_csr_wmask = '0; mem_wb_csr_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_allowin", 64'(wb_allowin), 64'd1);
        chk("rst_rf_we",   64'(rf_we), 64'd0);
        chk("rst_exc",     64'(wb_exc), 64'd0);
        chk("rst_csr_we",  64'(csr_we), 64'd0);
        chk("rst_ertn",    64'(ertn_flush), 64'd0);
        chk("rst_dbg_we",  64'(debug_wb_rf_we), 64'd0);
        chk("rst_blk",     64'(wb_csr_blk_bus), 64'd0);
        step();
        resetn = 1'b1;
        step();

        // two lanes commit, trace r3 then r4
        exp_tr(32'h1c000000, 5'd3, 32'h11);
        exp_tr(32'h1c000004, 5'd4, 32'h22);
        send(mk(1, 1, 0, 5'd3, 32'h11, 32'h1c000000, 6'h0),
             mk(1, 1, 0, 5'd4, 32'h22, 32'h1c000004, 6'h0), cur_ep);
        @(negedge clk);
        chk("c2_rf_we",    64'(rf_we), 64'd3);
        chk("c2_rf_waddr", 64'(rf_waddr), 64'({5'd4, 5'd3}));
        chk("c2_rf_wdata", 64'(rf_wdata), {32'h22, 32'h11});
        chk("c2_exc",      64'(wb_exc), 64'd0);
        drain();

        // lane 0 SYS: exception, no GPR writes, no trace
        send(mk(1, 1, 0, 5'd7, 32'h77, 32'h1c000010, 6'b001000),
             mk(1, 1, 0, 5'd8, 32'h88, 32'h1c000014, 6'h0), cur_ep);
        @(negedge clk);
        chk("sys_exc",   64'(wb_exc), 64'd1);
        chk("sys_ecode", 64'(wb_ecode), 64'h0b);
        chk("sys_rf_we", 64'(rf_we), 64'd0);
        chk("sys_pc",    64'(wb_pc), 64'h1c000010);
        step();
        cur_ep = ~cur_ep;

        // stale-epoch bundle is killed while flushing
        send(mk(1, 1, 0, 5'd5, 32'h55, 32'h1c000018, 6'h0),
             mk(1, 1, 0, 5'd6, 32'h66, 32'h1c00001c, 6'h0), ~cur_ep);
        @(negedge clk);
        chk("kill_rf_we", 64'(rf_we), 64'd0);
        chk("kill_exc",   64'(wb_exc), 64'd0);
        step();

        // new-epoch bundle commits and returns to RUN
        exp_tr(32'h1c000020, 5'd10, 32'ha0);
        exp_tr(32'h1c000024, 5'd11, 32'hb0);
        send(mk(1, 1, 0, 5'd10, 32'ha0, 32'h1c000020, 6'h0),
             mk(1, 1, 0, 5'd11, 32'hb0, 32'h1c000024, 6'h0), cur_ep);
        @(negedge clk);
        chk("new_ep_rf_we", 64'(rf_we), 64'd3);
        step();

        // in RUN an epoch mismatch no longer kills
        exp_tr(32'h1c000028, 5'd12, 32'hc0);
        send(mk(1, 1, 0, 5'd12, 32'hc0, 32'h1c000028, 6'h0), nil, ~cur_ep);
        @(negedge clk);
        chk("run_rf_we", 64'(rf_we), 64'd1);
        drain();

        // lane 1 ADEF+ALE: ADE wins, lane 0 still commits
        exp_tr(32'h1c000000, 5'd8, 32'h88);
        send(mk(1, 1, 0, 5'd8, 32'h88, 32'h1c000000, 6'h0),
             mk(1, 1, 0, 5'd9, 32'hdeadbeef, 32'h1c000004, 6'b100010), cur_ep);
        @(negedge clk);
        chk("ade_exc",      64'(wb_exc), 64'd1);
        chk("ade_ecode",    64'(wb_ecode), 64'h08);
        chk("ade_esub",     64'(wb_esubcode), 64'h0);
        chk("ade_pc",       64'(wb_pc), 64'h1c000004);
        chk("ade_badvaddr", 64'(wb_badvaddr), 64'hdeadbeef);
        chk("ade_rf_we",    64'(rf_we), 64'd1);
        step();
        cur_ep = ~cur_ep;
        drain();

        // CSR write on lane 0
        mem_wb_csr_we = 1'b1; mem_wb_csr_waddr = 14'h0006;
        mem_wb_csr_wmask = 32'hffff0000; mem_wb_csr_wdata = 32'h12345678;
        send(mk(1, 0, 0, 5'd0, 32'h0, 32'h1c000100, 6'h0), nil, cur_ep);
        @(negedge clk);
        chk("csr_we",    64'(csr_we), 64'd1);
        chk("csr_waddr", 64'(csr_waddr), 64'h6);
        chk("csr_wmask", 64'(csr_wmask), 64'hffff0000);
        chk("csr_wdata", 64'(csr_wdata), 64'h12345678);
        chk("csr_blk",   64'(wb_csr_blk_bus), 64'({1'b1, 1'b0, 14'h0006}));
        step();

        // ERTN on lane 0 suppresses lane 1
        mem_wb_csr_we = 1'b0;
        send(mk(1, 0, 1, 5'd0, 32'h0, 32'h1c000104, 6'h0),
             mk(1, 1, 0, 5'd13, 32'hd0, 32'h1c000108, 6'h0), cur_ep);
        @(negedge clk);
        chk("ertn_flush", 64'(ertn_flush), 64'd1);
        chk("ertn_rf_we", 64'(rf_we), 64'd0);
        chk("ertn_exc",   64'(wb_exc), 64'd0);
        chk("ertn_blk",   64'(wb_csr_blk_bus[14]), 64'd1);
        step();
        cur_ep = ~cur_ep;

        // lane-0 exception blocks its CSR write; INE outranks BRK
        mem_wb_csr_we = 1'b1;
        send(mk(1, 1, 0, 5'd14, 32'he0, 32'h1c000200, 6'b010100), nil, cur_ep);
        @(negedge clk);
        chk("cexc_csr_we", 64'(csr_we), 64'd0);
        chk("cexc_ecode",  64'(wb_ecode), 64'h0d);
        chk("cexc_rf_we",  64'(rf_we), 64'd0);
        step();
        cur_ep = ~cur_ep;
        mem_wb_csr_we = 1'b0;
        drain();

        // six back-to-back bundles: backpressure, no lost trace entries
        stalls = 0;
        for (int k = 0; k < 6; k++) begin
            exp_tr(32'h1c001000 + 32'(8 * k), 5'(2 * k + 1), 32'h100 + 32'(k));
            exp_tr(32'h1c001004 + 32'(8 * k), 5'(2 * k + 2), 32'h200 + 32'(k));
            send(mk(1, 1, 0, 5'(2 * k + 1), 32'h100 + 32'(k), 32'h1c001000 + 32'(8 * k), 6'h0),
                 mk(1, 1, 0, 5'(2 * k + 2), 32'h200 + 32'(k), 32'h1c001004 + 32'(8 * k), 6'h0),
                 cur_ep);
        end
        chk("b2b_stall", 64'(stalls > 0), 64'd1);
        drain();

        // reset with the trace FIFO holding entries discards them
        send(mk(1, 1, 0, 5'd20, 32'h2020, 32'h1c002000, 6'h0),
             mk(1, 1, 0, 5'd21, 32'h2121, 32'h1c002004, 6'h0), cur_ep);
        step();
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst_dbg_we",  64'(debug_wb_rf_we), 64'd0);
        chk("mrst_allowin", 64'(wb_allowin), 64'd1);
        step();
        resetn = 1'b1;
        cur_ep = 1'b0;
        repeat (6) @(negedge clk);
        chk("mrst_quiet", 64'(debug_wb_rf_we), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_stage_multi.md
WB_STAGE_MULTI -- requirements
Module: wb_stage_multi

Interface
REQ-001 Parameter LANES, 2, number of writeback lanes (1..4); lane 0 is the oldest instruction.
REQ-002 Parameter XLEN, 32, data/PC width.
REQ-003 Parameter TRACE_DEPTH, 4, debug trace FIFO entries (power of two, >= LANES).
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 mem_wb_valid  in  LANES  per-lane valid from MEM.
REQ-007 mem_wb_gr_we / mem_wb_ertn  in  LANES each  per-lane GPR write enable / ERTN flag.
REQ-008 mem_wb_dest  in  5*LANES; mem_wb_result, mem_wb_pc  in  XLEN*LANES; mem_wb_exc_type  in  6*LANES  per-lane fields, lane i at slice i.
REQ-009 mem_wb_epoch  in  1  flush epoch tag of the incoming bundle.
REQ-010 mem_wb_csr_we 1, mem_wb_csr_waddr 14, mem_wb_csr_wmask XLEN, mem_wb_csr_wdata XLEN  in  CSR write, carried by lane 0 only.
REQ-011 wb_allowin  out  1  stage can accept a bundle this cycle.
REQ-012 rf_we  out  LANES; rf_waddr  out  5*LANES; rf_wdata  out  XLEN*LANES  GPR write ports to ID.
REQ-013 csr_we 1, csr_waddr 14, csr_wmask XLEN, csr_wdata XLEN  out  CSR write port.
REQ-014 wb_exc 1, wb_ecode 6, wb_esubcode 9, wb_pc XLEN, wb_badvaddr XLEN, ertn_flush 1  out  exception/return to CSR file.
REQ-015 wb_csr_blk_bus  out  16  {csr_we pending, ertn_flush, csr_waddr} for ID hazard detection.
REQ-016 debug_wb_pc XLEN, debug_wb_rf_we 4, debug_wb_rf_wnum 5, debug_wb_rf_wdata XLEN  out  serialized trace, one entry/cycle.

Function
REQ-017 Bundle register SHALL load when (|mem_wb_valid) & wb_allowin; per-lane valid register loads mem_wb_valid, cleared when allowin & no incoming valid.
REQ-018 wb_allowin SHALL = ~(|wb_valid) | ready_go; ready_go = trace free entries >= LANES.
REQ-019 Kill: bundle killed when state==FLUSH and its epoch != epoch register; killed lanes produce no RF, CSR, exception, ertn or trace effect.
REQ-020 Excepting lane e = lowest valid unkilled lane with nonzero exc_type; lanes > e suppressed; lane e itself writes no GPR.
REQ-021 wb_exc SHALL = excepting lane exists & ready_go; wb_pc/wb_badvaddr = lane e pc/result.
REQ-022 ecode priority within lane e: INT > ADEF > INE > SYS > BRK > ALE; esubcode = ADEF subcode when ADEF selected, else 0.
REQ-023 ertn_flush SHALL = lane 0 valid, unkilled, ertn, no exception, ready_go; lanes 1.. suppressed when set.
REQ-024 csr_we SHALL = lane 0 valid, unkilled, csr_we, no lane-0 exception, ready_go.
REQ-025 rf_we[i] = wb_valid[i] & gr_we[i] & unkilled & unsuppressed & i != e & ready_go.
REQ-026 FSM RUN->FLUSH on wb_exc|ertn_flush, toggling epoch register same edge; FLUSH->RUN when an accepted bundle carries epoch == new epoch; exc in FLUSH re-toggles epoch and stays FLUSH.
REQ-027 Trace FIFO pushes, in lane order, one entry per lane with rf_we asserted, same cycle; pops one entry per cycle when non-empty; simultaneous push/pop allowed.
REQ-028 Debug outputs show FIFO head; debug_wb_rf_we = {4{head valid}}, 0 and other fields 0 when empty.
REQ-029 Pointers XLEN-independent, wrap modulo TRACE_DEPTH; never overflow (guaranteed by REQ-018).

Reset
REQ-030 On resetn low: wb_valid=0, state RUN, epoch 0, FIFO empty, bundle register 0; all rf/csr/exc/debug outputs 0, wb_allowin=1.
REQ-031 Reset mid-flush or with FIFO non-empty discards all contents without emitting trace.

Structure
REQ-032 Exception type bit indices, ECODE/ESUBCODE values and FSM state encoding SHALL live in the shared package/header.
REQ-033 Trace FIFO SHALL be sub-module wb_trace_fifo (multi-push, single-pop).

Verification
REQ-034 LANES=2, lanes write r3=0x11, r4=0x22 -> rf_we=2'b11; trace shows r3 then r4 on consecutive cycles.
REQ-035 Lane 0 exc_type=SYS, lane 1 gr_we -> wb_exc=1, ecode=0x0B, rf_we=0, no trace, state FLUSH.
REQ-036 After REQ-035, bundle with old epoch -> no effect; next bundle with new epoch -> commits, state RUN.
REQ-037 Lane 1 ADEF & ALE, pc 0x1c000004 -> ecode ADE, esubcode ADEF, wb_pc=0x1c000004, lane 0 commits.
REQ-038 Six back-to-back 2-lane bundles -> wb_allowin drops when free<2; all 12 trace entries appear in order, none lost.
